video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Generates raster timing and a built-in test pattern for the HDMI output path, one pixel per `hdmi_clk`. It sits directly upstream of the three-channel TMDS encoder. It drives that encoder's `data_en`, `hsync` and `vsync` inputs and its per-channel 8-bit pixel inputs `tmds_0`, `tmds_1` and `tmds_2`. All outputs are registered and mutually aligned, so the encoder consumes them without further skew compensation.

## Interface
- `H_ACTIVE`, 640: active pixels per line
- `H_FP`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: hsync width, in pixels
- `H_BP`, 48: horizontal back porch, in pixels
- `V_ACTIVE`, 480: active lines per frame
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vsync width, in lines
- `V_BP`, 33: vertical back porch, in lines
- `HS_POL`, 0: hsync active level (0 = active-low)
- `VS_POL`, 0: vsync active level (0 = active-low)
- `hdmi_clk`  in  1  pixel clock; the only clock
- `reset`  in  1  asynchronous, active-high reset
- `pattern_sel`  in  2  0 = colour bars, 1 = solid white, 2 = grey ramp, 3 = black
- `data_en`  out  1  high during active video
- `hsync`  out  1  horizontal sync, at `HS_POL` when asserted
- `vsync`  out  1  vertical sync, at `VS_POL` when asserted
- `x`  out  12  active pixel column; 0 during blanking
- `y`  out  12  active line number; 0 during blanking
- `frame_start`  out  1  one-cycle pulse coincident with pixel (0,0)
- `tmds_0`  out  8  blue component
- `tmds_1`  out  8  green component
- `tmds_2`  out  8  red component

## Operation
- Derived totals: `H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP`; `V_TOTAL` is formed the same way from the vertical parameters.
- Horizontal counter `h_cnt` (12 bits) runs 0 .. `H_TOTAL-1`, then wraps to 0.
- Vertical counter `v_cnt` (12 bits) increments only when `h_cnt` wraps. It runs 0 .. `V_TOTAL-1`, then wraps to 0.
- Active region: `h_cnt < H_ACTIVE` and `v_cnt < V_ACTIVE`.
- hsync is asserted while `H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC`.
- vsync is asserted while `V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC`. It changes only at `h_cnt` = 0, so vsync edges are aligned to line start.
- `pattern_sel` is captured into a shadow register only when `h_cnt` = 0 and `v_cnt` = 0. A change therefore takes effect at the next frame and never mid-frame.
- Colour bars: 8 bars, each `BAR_W = H_ACTIVE/8` pixels wide. Order is white, yellow, cyan, green, magenta, red, blue, black.
  - Each component is either 0x00 or 0xFF.
  - The bar index comes from a sub-counter that resets at `h_cnt` = 0. There is no divider.
  - Any leftover pixels when `H_ACTIVE` is not a multiple of 8 stay black.
- Grey ramp: all three channels equal `x[7:0]`.
- During blanking, `tmds_0`, `tmds_1` and `tmds_2` are all 0x00, whatever the pattern.
- Reset values:
  - Counters are 0.
  - `data_en`, `frame_start`, `x`, `y` and `tmds_*` are 0.
  - `hsync` = `~HS_POL` and `vsync` = `~VS_POL` (inactive).
  - The pattern shadow register resets to colour bars.
- Reset asserted mid-frame forces all of the above values immediately and asynchronously. After release, the raster restarts from (0,0).

## Timing
- Latency is 1 cycle: every output is registered from the counter values of the previous cycle.
- All outputs describe the same pixel in the same cycle.
- After `reset` falls:
  - The first rising edge of `hdmi_clk` registers the outputs for (0,0).
  - `frame_start` and `data_en` are both high after that edge.
- The `frame_start` period is exactly `H_TOTAL*V_TOTAL` cycles (420000 with the default parameters).
- The `data_en` high run is exactly `H_ACTIVE` cycles per active line. `data_en` stays low for all `V_TOTAL-V_ACTIVE` blanking lines.
- `x` counts 0 .. `H_ACTIVE-1` while `data_en` is high. `y` holds constant across each line.

## Structure
- Shared package `video_timing_pkg` holds:
  - default 640x480@60 timing constants;
  - the pattern-select encodings `PAT_BARS`, `PAT_WHITE`, `PAT_RAMP` and `PAT_BLACK`;
  - the 8-entry bar colour constants as 24-bit RGB values.
- Sub-module `video_pattern_gen` maps (`x`, bar index, captured pattern) to the three components. It is combinational and feeds the output register.
- Counters, sync decode and output registers live in the top level.

## Test plan
- Reset behaviour: hold `reset` high for 10 cycles.
  - During reset: `hsync` = 1, `vsync` = 1, `data_en` = 0, `tmds_*` = 0x00.
  - First edge after release: `frame_start` = 1, `x` = 0, `y` = 0.
- Line timing, default parameters:
  - `data_en` stays high for 640 cycles.
  - `hsync` falls 656 cycles after `data_en` rises and stays low for 96 cycles.
  - The line period is 800 cycles.
- Frame timing:
  - 525 lines per frame; `vsync` is low on lines 490 and 491 only.
  - `frame_start` pulses every 420000 cycles.
  - `y` = 479 on the last active line.
- Colour bars (`pattern_sel` = 0), checked as (`tmds_2`, `tmds_1`, `tmds_0`):
  - `x` = 0 → FF/FF/FF;
  - `x` = 80 → FF/FF/00;
  - `x` = 400 → FF/00/00;
  - `x` = 639 → 00/00/00;
  - `h_cnt` = 700 (blanking) → 00/00/00.
- Pattern switch: change `pattern_sel` from 0 to 2 at line 100.
  - The rest of the current frame stays colour bars.
  - On the next frame, `x` = 37 gives all channels = 0x25.
- Reset mid-operation: assert `reset` asynchronously at line 300, pixel 200.
  - Outputs take their reset values before the next edge.
  - After release, the raster restarts at (0,0) with `frame_start` = 1.

Source files
------------

// File: rtl/video_timing_pkg.sv
// video_timing_pkg: default 640x480@60 timing, pattern encodings and colour-bar palette.
// Rev 1.0
`default_nettype none

package video_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_WHITE = 2'd1,
    PAT_RAMP  = 2'd2,
    PAT_BLACK = 2'd3
  } pattern_t;

  // Bar palette, 24-bit RGB with red in the top byte.
  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  // Index 8 and above covers the leftover pixels right of the last bar.
  function automatic logic [23:0] bar_color(input logic [3:0] idx);
    case (idx)
      4'd0:    return BAR_WHITE;
      4'd1:    return BAR_YELLOW;
      4'd2:    return BAR_CYAN;
      4'd3:    return BAR_GREEN;
      4'd4:    return BAR_MAGENTA;
      4'd5:    return BAR_RED;
      4'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: combinational test-pattern colour for the current pixel.
// Rev 1.0
`default_nettype none

module video_pattern_gen
  import video_timing_pkg::*;
(
  input  logic [7:0] x,
  input  logic [3:0] bar_idx,
  input  pattern_t   pattern,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue
);

  logic [23:0] rgb;

  always_comb begin
    rgb = '0;
    case (pattern)
      PAT_BARS:  rgb = bar_color(bar_idx);
      PAT_WHITE: rgb = 24'hFFFFFF;
      PAT_RAMP:  rgb = {x, x, x};
      PAT_BLACK: rgb = '0;
      default:   rgb = '0;
    endcase
  end

  assign {red, green, blue} = rgb;

endmodule

`default_nettype wire

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster counters, sync decode and registered pixel outputs for the TMDS encoder.
// Rev 1.0
`default_nettype none

module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        hdmi_clk,
  input  logic        reset,
  input  logic [1:0]  pattern_sel,
  output logic        data_en,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        frame_start,
  output logic [7:0]  tmds_0,
  output logic [7:0]  tmds_1,
  output logic [7:0]  tmds_2
);

  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYNC_S = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_E = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] V_SYNC_S = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_E = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic [11:0] bar_cnt;
  logic [3:0]  bar_idx;
  pattern_t    pat_q;
  pattern_t    pat_cur;
  logic        h_wrap;
  logic        v_wrap;
  logic        frame_top;
  logic        active;
  logic        hs_on;
  logic        vs_on;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;

  assign h_wrap    = (h_cnt == H_LAST);
  assign v_wrap    = (v_cnt == V_LAST);
  assign frame_top = (h_cnt == '0) && (v_cnt == '0);
  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_on     = (h_cnt >= H_SYNC_S) && (h_cnt < H_SYNC_E);
  assign vs_on     = (v_cnt >= V_SYNC_S) && (v_cnt < V_SYNC_E);

  // Pixel (0,0) already belongs to the new frame, so it uses the value being captured.
  assign pat_cur = frame_top ? pattern_t'(pattern_sel) : pat_q;

  video_pattern_gen u_pattern (
    .x       (h_cnt[7:0]),
    .bar_idx (bar_idx),
    .pattern (pat_cur),
    .red     (red),
    .green   (green),
    .blue    (blue)
  );

  always_ff @(posedge hdmi_clk or posedge reset) begin
    if (reset) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      bar_cnt <= '0;
      bar_idx <= '0;
      pat_q   <= PAT_BARS;
    end else begin
      h_cnt <= h_wrap ? '0 : h_cnt + 12'd1;
      if (h_wrap) begin
        v_cnt <= v_wrap ? '0 : v_cnt + 12'd1;
      end
      if (frame_top) begin
        pat_q <= pattern_t'(pattern_sel);
      end
      // Bar index tracks h_cnt without a divider; it saturates at 8 (black filler).
      if (h_wrap) begin
        bar_cnt <= '0;
        bar_idx <= '0;
      end else if (bar_cnt == BAR_LAST) begin
        bar_cnt <= '0;
        if (bar_idx != 4'd8) begin
          bar_idx <= bar_idx + 4'd1;
        end
      end else begin
        bar_cnt <= bar_cnt + 12'd1;
      end
    end
  end

  always_ff @(posedge hdmi_clk or posedge reset) begin
    if (reset) begin
      data_en     <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      tmds_0      <= '0;
      tmds_1      <= '0;
      tmds_2      <= '0;
    end else begin
      data_en     <= active;
      hsync       <= hs_on ? HS_POL : ~HS_POL;
      vsync       <= vs_on ? VS_POL : ~VS_POL;
      x           <= active ? h_cnt : '0;
      y           <= active ? v_cnt : '0;
      frame_start <= frame_top;
      tmds_0      <= active ? blue  : '0;
      tmds_1      <= active ? green : '0;
      tmds_2      <= active ? red   : '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: reduced-raster bench with a per-cycle behavioural model and literal spot checks.
// Rev 1.0
`default_nettype none

module tb_video_timing_gen;

  localparam int HA  = 44;
  localparam int HFP = 4;
  localparam int HSW = 6;
  localparam int HBP = 6;
  localparam int VA  = 8;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VBP = 3;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int FT  = HT * VT;
  localparam int BW  = HA / 8;
  localparam bit HS_POL = 1'b0;
  localparam bit VS_POL = 1'b0;

  logic        clk;
  logic        reset;
  logic [1:0]  pattern_sel;
  logic        data_en;
  logic        hsync;
  logic        vsync;
  logic [11:0] x;
  logic [11:0] y;
  logic        frame_start;
  logic [7:0]  tmds_0;
  logic [7:0]  tmds_1;
  logic [7:0]  tmds_2;

  int checks = 0;
  int errors = 0;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) dut (
    .hdmi_clk    (clk),
    .reset       (reset),
    .pattern_sel (pattern_sel),
    .data_en     (data_en),
    .hsync       (hsync),
    .vsync       (vsync),
    .x           (x),
    .y           (y),
    .frame_start (frame_start),
    .tmds_0      (tmds_0),
    .tmds_1      (tmds_1),
    .tmds_2      (tmds_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [11:0] px;
    logic [11:0] py;
    logic [23:0] rgb;
  } exp_t;

  function automatic logic [23:0] bar_rgb(input int b);
    case (b)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e.de = 1'b0; e.hs = ~HS_POL; e.vs = ~VS_POL; e.fs = 1'b0;
    e.px = '0;   e.py = '0;      e.rgb = '0;
    return e;
  endfunction

  // Pixel number kk since reset release, with the pattern of the frame it belongs to.
  function automatic exp_t model_px(input int kk, input logic [1:0] pat);
    exp_t e;
    int h, v;
    logic act;
    logic [7:0] h8;
    h = kk % HT;
    v = (kk / HT) % VT;
    act = (h < HA) && (v < VA);
    h8 = 8'(h);
    e.de = act;
    e.hs = (h >= HA + HFP && h < HA + HFP + HSW) ? HS_POL : ~HS_POL;
    e.vs = (v >= VA + VFP && v < VA + VFP + VSW) ? VS_POL : ~VS_POL;
    e.fs = (h == 0) && (v == 0);
    e.px = act ? 12'(h) : 12'd0;
    e.py = act ? 12'(v) : 12'd0;
    e.rgb = '0;
    if (act) begin
      case (pat)
        2'd0: e.rgb = bar_rgb(h / BW);
        2'd1: e.rgb = 24'hFFFFFF;
        2'd2: e.rgb = {h8, h8, h8};
        default: e.rgb = 24'h000000;
      endcase
    end
    return e;
  endfunction

  int         k = 0;
  logic [1:0] mpat = 2'd0;
  exp_t       exp_q;
  bit         model_valid = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      k           <= 0;
      mpat        <= 2'd0;
      exp_q       <= reset_exp();
      model_valid <= 1'b1;
    end else if (model_valid) begin
      if (k % FT == 0) begin
        mpat  <= pattern_sel;
        exp_q <= model_px(k, pattern_sel);
      end else begin
        exp_q <= model_px(k, mpat);
      end
      k <= k + 1;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("data_en", 32'(data_en), 32'(exp_q.de));
      check("hsync", 32'(hsync), 32'(exp_q.hs));
      check("vsync", 32'(vsync), 32'(exp_q.vs));
      check("frame_start", 32'(frame_start), 32'(exp_q.fs));
      check("x", 32'(x), 32'(exp_q.px));
      check("y", 32'(y), 32'(exp_q.py));
      check("rgb", 32'({tmds_2, tmds_1, tmds_0}), 32'(exp_q.rgb));
    end
  end

  // ---------------- stimulus and literal checks ----------------
  task automatic step_to(input int kk);
    int guard;
    guard = 0;
    while (k != kk + 1 && guard < 20000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 20000) check("step_timeout", 32'(k), 32'(kk + 1));
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic rgb_is(input string name, input logic [23:0] want);
    check(name, 32'({tmds_2, tmds_1, tmds_0}), 32'(want));
  endtask

  initial begin
    int t;
    int target;
    reset = 1'b1;
    pattern_sel = 2'd0;
    repeat (10) @(negedge clk);
    check("rst_hsync", 32'(hsync), 32'd1);
    check("rst_vsync", 32'(vsync), 32'd1);
    check("rst_de", 32'(data_en), 32'd0);
    rgb_is("rst_rgb", 24'h000000);
    reset = 1'b0;

    step_to(0);
    check("first_fs", 32'(frame_start), 32'd1);
    check("first_de", 32'(data_en), 32'd1);
    check("first_x", 32'(x), 32'd0);
    check("first_y", 32'(y), 32'd0);
    rgb_is("bar_x0", 24'hFFFFFF);
    step_to(5);  rgb_is("bar_x5", 24'hFFFF00);
    step_to(25); rgb_is("bar_x25", 24'hFF0000);
    step_to(39); rgb_is("bar_x39", 24'h000000);
    step_to(43); rgb_is("bar_leftover", 24'h000000);
    check("x_last", 32'(x), 32'(HA - 1));
    step_to(50); rgb_is("blank_rgb", 24'h000000);

    // Line timing measured from the data_en rise of line 1.
    step_to(HT);
    t = 0;
    while (data_en === 1'b1 && t < 200) begin adv(); t++; end
    check("de_run", 32'(t), 32'(HA));
    while (hsync !== 1'b0 && t < 200) begin adv(); t++; end
    check("hsync_delay", 32'(t), 32'(HA + HFP));
    while (hsync === 1'b0 && t < 200) begin adv(); t++; end
    check("hsync_width", 32'(t), 32'(HA + HFP + HSW));
    while (data_en !== 1'b1 && t < 200) begin adv(); t++; end
    check("line_period", 32'(t), 32'(HT));

    // Switch to the ramp mid-frame; bars must persist until the next frame.
    step_to(3 * HT + 10);
    pattern_sel = 2'd2;
    step_to(4 * HT + 5);  rgb_is("bars_hold", 24'hFFFF00);
    step_to(7 * HT + 3);  check("y_last", 32'(y), 32'(VA - 1));
    step_to(10 * HT - 1); check("vs_before", 32'(vsync), 32'd1);
    step_to(10 * HT);     check("vs_start", 32'(vsync), 32'd0);
    step_to(11 * HT + 59); check("vs_hold", 32'(vsync), 32'd0);
    step_to(12 * HT);     check("vs_end", 32'(vsync), 32'd1);
    step_to(FT + 37);     rgb_is("ramp_x37", 24'h252525);

    // Frame period between consecutive frame_start pulses.
    t = 0;
    while (frame_start !== 1'b1 && t < 2 * FT) begin adv(); t++; end
    adv();
    t = 1;
    while (frame_start !== 1'b1 && t < 2 * FT) begin adv(); t++; end
    check("frame_period", 32'(t), 32'(FT));

    repeat (2 * FT) begin
      @(negedge clk);
      pattern_sel = 2'($urandom_range(0, 3));
    end

    // Asynchronous reset in the middle of an active line.
    target = ((k / FT) + 1) * FT + 5 * HT + 20;
    step_to(target);
    #1;
    reset = 1'b1;
    #1;
    check("async_de", 32'(data_en), 32'd0);
    check("async_hsync", 32'(hsync), 32'd1);
    check("async_vsync", 32'(vsync), 32'd1);
    check("async_x", 32'(x), 32'd0);
    check("async_y", 32'(y), 32'd0);
    rgb_is("async_rgb", 24'h000000);
    repeat (3) @(negedge clk);
    pattern_sel = 2'd1;
    reset = 1'b0;
    step_to(0);
    check("restart_fs", 32'(frame_start), 32'd1);
    check("restart_x", 32'(x), 32'd0);
    check("restart_y", 32'(y), 32'd0);
    rgb_is("restart_white", 24'hFFFFFF);

    repeat (2 * FT) begin
      @(negedge clk);
      pattern_sel = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
